// File: rtl/mpsk_phase_gen.sv
// M-ary PSK phase generator: buffers symbols in a small FIFO and emits the sine-LUT
// index (carrier position plus symbol phase offset), registered with one-cycle latency.
module mpsk_phase_gen #(
    parameter int SINE_RESOLUTION   = 256,
    parameter int WAVELENGTH        = 16,
    parameter int BITS_PER_SYMBOL   = 2,
    parameter int CYCLES_PER_SYMBOL = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int GRAY              = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BITS_PER_SYMBOL-1:0]         sym_data,
    input  logic                               sym_valid,
    output logic                               sym_ready,
    output logic [$clog2(SINE_RESOLUTION)-1:0] phase,
    output logic                               sym_active,
    output logic                               sym_start,
    output logic                               underrun
);
    localparam int PHASE_W = $clog2(SINE_RESOLUTION);
    localparam int STEP    = SINE_RESOLUTION / WAVELENGTH;
    localparam int STEP_SH = $clog2(STEP);
    localparam int IDX_W   = (WAVELENGTH > 1) ? $clog2(WAVELENGTH) : 1;
    localparam int CYC_W   = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int OFF_SH  = PHASE_W - BITS_PER_SYMBOL;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_index;
    logic [CYC_W-1:0]           r_cyc;
    logic [PHASE_W-1:0]         r_cur_offset;
    logic [PHASE_W-1:0]         w_offset_nxt;
    logic [PHASE_W-1:0]         w_new_offset;
    logic [PHASE_W-1:0]         w_carrier;
    logic [BITS_PER_SYMBOL-1:0] w_head;
    logic [BITS_PER_SYMBOL-1:0] w_sym_map;
    logic                       w_index_wrap;
    logic                       w_boundary;
    logic                       w_underrun_evt;

    logic [BITS_PER_SYMBOL-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;

    logic [PHASE_W-1:0]         r_phase;
    logic                       r_sym_active;
    logic                       r_popped;
    logic                       r_sym_start;
    logic                       r_und_evt;
    logic                       r_underrun;

    assign w_index_wrap = (r_index == IDX_W'(WAVELENGTH - 1));
    assign w_boundary   = w_index_wrap && (r_cyc == CYC_W'(CYCLES_PER_SYMBOL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_cyc   <= '0;
        end else begin
            r_index <= w_index_wrap ? '0 : r_index + IDX_W'(1);
            if (w_index_wrap) begin
                r_cyc <= (r_cyc == CYC_W'(CYCLES_PER_SYMBOL - 1)) ? '0 : r_cyc + CYC_W'(1);
            end
        end
    end

    // Pop only looks at the pre-push count, so a symbol never bypasses the buffer.
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign sym_ready = !w_full;
    assign w_push    = sym_valid && !w_full;
    assign w_pop     = w_boundary && !w_empty;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sym_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_sym_map    = (GRAY != 0) ? (w_head ^ (w_head >> 1)) : w_head;
    assign w_new_offset = PHASE_W'(w_sym_map) << OFF_SH;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur_offset <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_offset <= w_offset_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_offset_nxt   = r_cur_offset;
        w_underrun_evt = 1'b0;
        if (w_boundary) begin
            if (!w_empty) begin
                w_state_nxt  = S_RUN;
                w_offset_nxt = w_new_offset;
            end else begin
                w_state_nxt    = S_IDLE;
                w_offset_nxt   = '0;
                w_underrun_evt = (r_state == S_RUN);
            end
        end
    end

    // Flags are delayed so that they line up with the phase sample they describe.
    assign w_carrier = PHASE_W'(r_index) << STEP_SH;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= '0;
            r_sym_active <= 1'b0;
            r_popped     <= 1'b0;
            r_sym_start  <= 1'b0;
            r_und_evt    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_phase      <= w_carrier + r_cur_offset;
            r_sym_active <= (r_state == S_RUN);
            r_popped     <= w_pop;
            r_sym_start  <= r_popped;
            r_und_evt    <= w_underrun_evt;
            r_underrun   <= r_und_evt;
        end
    end

    assign phase      = r_phase;
    assign sym_active = r_sym_active;
    assign sym_start  = r_sym_start;
    assign underrun   = r_underrun;
endmodule

// File: tb/tb_mpsk_phase_gen.sv
// Bench for mpsk_phase_gen: a QPSK/Gray instance and a BPSK instance fed from the same
// stimulus, checked against a cycle-count/queue model of the PSK rules.
module tb_mpsk_phase_gen;
    localparam int SR    = 256;
    localparam int W     = 16;
    localparam int CPS   = 2;
    localparam int PER   = W * CPS;
    localparam int DEPTH = 4;
    localparam int STEP  = SR / W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_data = 2'd0;

    logic       a_ready, a_active, a_start, a_und;
    logic [7:0] a_phase;
    logic       b_ready, b_active, b_start, b_und;
    logic [7:0] b_phase;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int k;
    int q[$];
    bit run;
    int off_a, off_b;
    int e_phase_a, e_phase_b;
    bit e_active, e_start, e_und, e_ready;
    bit popped_prev, und_prev;

    always #5 clk = ~clk;

    mpsk_phase_gen u_qpsk (
        .clk(clk), .rst(rst), .sym_data(sym_data), .sym_valid(sym_valid),
        .sym_ready(a_ready), .phase(a_phase), .sym_active(a_active),
        .sym_start(a_start), .underrun(a_und)
    );

    mpsk_phase_gen #(.BITS_PER_SYMBOL(1)) u_bpsk (
        .clk(clk), .rst(rst), .sym_data(sym_data[0:0]), .sym_valid(sym_valid),
        .sym_ready(b_ready), .phase(b_phase), .sym_active(b_active),
        .sym_start(b_start), .underrun(b_und)
    );

    function automatic int qpsk_off(int s);
        return (s ^ (s >> 1)) * (SR / 4);
    endfunction

    function automatic int bpsk_off(int s);
        return (s & 1) * (SR / 2);
    endfunction

    task automatic model_step();
        bit push;
        int s;
        bit popped_now, und_now;
        if (rst) begin
            k = 0; q.delete(); run = 0; off_a = 0; off_b = 0;
            e_phase_a = 0; e_phase_b = 0; e_active = 0; e_start = 0; e_und = 0;
            popped_prev = 0; und_prev = 0; e_ready = 1;
            return;
        end
        e_phase_a = ((k % W) * STEP + off_a) % SR;
        e_phase_b = ((k % W) * STEP + off_b) % SR;
        e_active  = run;
        e_start   = popped_prev;
        e_und     = und_prev;
        popped_now = 0;
        und_now    = 0;
        push = sym_valid && (q.size() < DEPTH);
        if ((k % PER) == PER - 1) begin
            if (q.size() > 0) begin
                s = q.pop_front();
                off_a = qpsk_off(s);
                off_b = bpsk_off(s);
                run = 1;
                popped_now = 1;
            end else begin
                und_now = run;
                run = 0; off_a = 0; off_b = 0;
            end
        end
        if (push) q.push_back(int'(sym_data));
        k++;
        popped_prev = popped_now;
        und_prev    = und_now;
        e_ready     = (q.size() < DEPTH);
    endtask

    task automatic cycle(input bit v, input int d);
        sym_valid = v;
        sym_data  = d[1:0];
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(0, 0);
        cycle(0, 0);
        checks++;
        if (a_phase !== 8'd0 || a_active !== 1'b0 || a_start !== 1'b0 || a_und !== 1'b0) begin
            $display("FAIL reset_outputs: phase=%0d act=%b start=%b und=%b, want 0/0/0/0",
                     a_phase, a_active, a_start, a_und);
            errors++;
        end
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            $display("FAIL reset_ready: a=%b b=%b, want 1", a_ready, b_ready);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_carrier();
        for (int i = 0; i < 2 * PER; i++) begin
            cycle(0, 0);
            checks++;
            if (a_phase !== 8'(e_phase_a) || b_phase !== 8'(e_phase_b)) begin
                $display("FAIL idle_phase cyc%0d: a=%0d b=%0d, want %0d", i, a_phase, b_phase, e_phase_a);
                errors++;
            end
            checks++;
            if (a_active !== 1'b0 || a_start !== 1'b0 || a_und !== 1'b0 || a_ready !== 1'b1) begin
                $display("FAIL idle_flags cyc%0d: act=%b start=%b und=%b rdy=%b, want 0001",
                         i, a_active, a_start, a_und, a_ready);
                errors++;
            end
        end
    endtask

    task automatic test_single_symbol();
        int starts = 0;
        int unds = 0;
        cycle(1, 1);
        for (int i = 0; i < 3 * PER; i++) begin
            cycle(0, 0);
            starts += int'(a_start);
            unds   += int'(a_und);
            checks++;
            if (a_phase !== 8'(e_phase_a) || b_phase !== 8'(e_phase_b) || a_active !== e_active
                || a_start !== e_start || a_und !== e_und) begin
                $display("FAIL single_sym cyc%0d: ph=%0d/%0d act=%b st=%b und=%b, want ph=%0d/%0d act=%b st=%b und=%b",
                         i, a_phase, b_phase, a_active, a_start, a_und,
                         e_phase_a, e_phase_b, e_active, e_start, e_und);
                errors++;
            end
        end
        checks++;
        if (starts != 1 || unds != 1) begin
            $display("FAIL single_sym_pulses: starts=%0d underruns=%0d, want 1 and 1", starts, unds);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int starts = 0;
        int unds = 0;
        int first_start = -1;
        int gap = 0;
        cycle(1, 2);
        cycle(1, 3);
        for (int i = 0; i < 4 * PER; i++) begin
            cycle(0, 0);
            if (a_start === 1'b1) begin
                if (first_start < 0) first_start = i;
                else gap = i - first_start;
            end
            starts += int'(a_start);
            unds   += int'(a_und);
            checks++;
            if (a_phase !== 8'(e_phase_a) || b_phase !== 8'(e_phase_b) || a_active !== e_active
                || a_start !== e_start || a_und !== e_und || b_start !== e_start) begin
                $display("FAIL b2b cyc%0d: ph=%0d/%0d act=%b st=%b und=%b, want ph=%0d/%0d act=%b st=%b und=%b",
                         i, a_phase, b_phase, a_active, a_start, a_und,
                         e_phase_a, e_phase_b, e_active, e_start, e_und);
                errors++;
            end
        end
        checks++;
        if (starts != 2 || unds != 1 || gap != PER) begin
            $display("FAIL b2b_pulses: starts=%0d underruns=%0d gap=%0d, want 2 1 %0d", starts, unds, gap, PER);
            errors++;
        end
    endtask

    task automatic test_fifo_full();
        int accepted = 0;
        rst = 1'b1;
        cycle(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (a_ready === 1'b1) accepted++;
            cycle(1, i);
            checks++;
            if (a_ready !== e_ready || b_ready !== e_ready) begin
                $display("FAIL fifo_ready push%0d: a=%b b=%b, want %b", i, a_ready, b_ready, e_ready);
                errors++;
            end
        end
        checks++;
        if (accepted != DEPTH || a_ready !== 1'b0) begin
            $display("FAIL fifo_accept: accepted=%0d ready=%b, want %0d and 0", accepted, a_ready, DEPTH);
            errors++;
        end
        for (int i = 0; i < 6 * PER; i++) begin
            cycle(1, 3);
            checks++;
            if (a_ready !== e_ready || a_phase !== 8'(e_phase_a) || a_start !== e_start
                || a_active !== e_active || a_und !== e_und) begin
                $display("FAIL fifo_drain cyc%0d: rdy=%b ph=%0d st=%b, want rdy=%b ph=%0d st=%b",
                         i, a_ready, a_phase, a_start, e_ready, e_phase_a, e_start);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        cycle(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, i);
        for (int i = 0; i < PER; i++) cycle(0, 0);
        checks++;
        if (a_active !== 1'b1 || e_active !== 1'b1 || q.size() != 3 || a_ready !== 1'b1) begin
            $display("FAIL midrun_setup: act=%b ready=%b buffered=%0d, want 1 1 3", a_active, a_ready, q.size());
            errors++;
        end
        rst = 1'b1;
        cycle(0, 0);
        rst = 1'b0;
        checks++;
        if (a_phase !== 8'd0 || a_active !== 1'b0 || a_ready !== 1'b1 || a_start !== 1'b0 || a_und !== 1'b0) begin
            $display("FAIL midrun_reset: ph=%0d act=%b rdy=%b st=%b und=%b, want 0 0 1 0 0",
                     a_phase, a_active, a_ready, a_start, a_und);
            errors++;
        end
        for (int i = 0; i < 3 * PER; i++) begin
            cycle(0, 0);
            checks++;
            if (a_phase !== 8'(e_phase_a) || a_active !== 1'b0 || a_und !== 1'b0 || a_start !== 1'b0) begin
                $display("FAIL midrun_after cyc%0d: ph=%0d act=%b und=%b st=%b, want ph=%0d and no flags",
                         i, a_phase, a_active, a_und, a_start, e_phase_a);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        cycle(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            cycle(($urandom_range(0, 39) == 0), int'($urandom_range(0, 3)));
            checks++;
            if (a_phase !== 8'(e_phase_a) || b_phase !== 8'(e_phase_b) || a_active !== e_active
                || a_start !== e_start || a_und !== e_und || a_ready !== e_ready
                || b_active !== e_active || b_start !== e_start || b_und !== e_und || b_ready !== e_ready) begin
                $display("FAIL random cyc%0d: ph=%0d/%0d act=%b st=%b und=%b rdy=%b, want ph=%0d/%0d act=%b st=%b und=%b rdy=%b",
                         i, a_phase, b_phase, a_active, a_start, a_und, a_ready,
                         e_phase_a, e_phase_b, e_active, e_start, e_und, e_ready);
                errors++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_carrier();
        test_single_symbol();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
